// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// muldiv_pkg
// Shared state encoding, op codes and sizing helper for seq_muldiv.
// Revision: 1.0
// ============================================================================
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Bits needed to represent values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_addsub.sv
`default_nettype none
// ============================================================================
// muldiv_addsub
// WIDTH+1-bit adder/subtractor; co is carry out when adding, borrow when subtracting.
// Revision: 1.0
// ============================================================================
module muldiv_addsub
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0] x,
    input  logic [WIDTH:0] y,
    input  logic           sub,
    output logic [WIDTH:0] sum,
    output logic           co
);

    logic [WIDTH:0]   w_y;
    logic [WIDTH+1:0] w_full;

    assign w_y    = sub ? ~y : y;
    assign w_full = {1'b0, x} + {1'b0, w_y} + {{(WIDTH + 1){1'b0}}, sub};
    assign sum    = w_full[WIDTH:0];
    assign co     = w_full[WIDTH+1] ^ sub;

endmodule
`default_nettype wire

// File: rtl/seq_muldiv.sv
`default_nettype none
// ============================================================================
// seq_muldiv
// Iterative shift-add multiplier / restoring divider, one bit per clock.
// Optional macro SEQ_MULDIV_SIGNED_EN adds the signed_op input (two's complement).
// Revision: 1.0
// ============================================================================
module seq_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
`ifdef SEQ_MULDIV_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    localparam int               c_cnt_w = clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_op;
    logic               r_div0;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_res_hi;
    logic [WIDTH-1:0]   r_res_lo;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_div0;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_x;
    logic [WIDTH:0]     w_y;
    logic               w_sub;
    logic [WIDTH:0]     w_sum;
    logic               w_co;
    logic [WIDTH:0]     w_sel;
    logic [WIDTH-1:0]   w_nhi;
    logic [WIDTH-1:0]   w_nlo;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

`ifdef SEQ_MULDIV_SIGNED_EN
    logic r_neg_lo;
    logic r_neg_hi;
    logic w_neg_lo;
    logic w_neg_hi;

    // Iterate on magnitudes; signs are restored on the edge entering DONE.
    assign w_a_mag  = (signed_op && a[WIDTH-1]) ? -a : a;
    assign w_b_mag  = (signed_op && b[WIDTH-1]) ? -b : b;
    assign w_neg_lo = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
    assign w_neg_hi = signed_op && a[WIDTH-1];
`else
    assign w_a_mag = a;
    assign w_b_mag = b;
`endif

    assign w_div0  = (op == OP_DIV) && (b == '0);
    assign w_shift = {r_hi, r_lo[WIDTH-1]};

    always_comb begin
        w_x   = {1'b0, r_hi};
        w_y   = {1'b0, r_opnd};
        w_sub = 1'b0;
        if (r_op == OP_DIV) begin
            w_x   = w_shift;
            w_sub = 1'b1;
        end
    end

    muldiv_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .x   (w_x),
        .y   (w_y),
        .sub (w_sub),
        .sum (w_sum),
        .co  (w_co)
    );

    // Next working value: restoring step for divide, add-then-shift for multiply.
    always_comb begin
        w_sel = {1'b0, r_hi};
        w_nhi = r_hi;
        w_nlo = r_lo;
        if (r_op == OP_DIV) begin
            w_nhi = w_co ? w_shift[WIDTH-1:0] : w_sum[WIDTH-1:0];
            w_nlo = {r_lo[WIDTH-2:0], ~w_co};
        end else begin
            w_sel = r_lo[0] ? w_sum : {1'b0, r_hi};
            w_nhi = w_sel[WIDTH:1];
            w_nlo = {w_sel[0], r_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        w_res_hi = w_nhi;
        w_res_lo = w_nlo;
`ifdef SEQ_MULDIV_SIGNED_EN
        if (r_op == OP_MUL) begin
            if (r_neg_lo) begin
                {w_res_hi, w_res_lo} = -{w_nhi, w_nlo};
            end
        end else begin
            if (r_neg_lo) begin
                w_res_lo = -w_nlo;
            end
            if (r_neg_hi) begin
                w_res_hi = -w_nhi;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_op     <= OP_MUL;
            r_div0   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
`ifdef SEQ_MULDIV_SIGNED_EN
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_op    <= op;
                        r_div0  <= w_div0;
                        r_cnt   <= '0;
                        r_hi    <= '0;
                        r_opnd  <= (op == OP_DIV) ? w_b_mag : w_a_mag;
                        // A zero divisor keeps the raw dividend for result_hi.
                        r_lo    <= w_div0 ? a : ((op == OP_DIV) ? w_a_mag : w_b_mag);
`ifdef SEQ_MULDIV_SIGNED_EN
                        r_neg_lo <= w_neg_lo;
                        r_neg_hi <= w_neg_hi;
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    if (r_div0) begin
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_res_hi <= r_lo;
                        r_res_lo <= '1;
                        r_dbz    <= 1'b1;
                    end else begin
                        r_hi  <= w_nhi;
                        r_lo  <= w_nlo;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_last) begin
                            r_state  <= DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_res_hi <= w_res_hi;
                            r_res_lo <= w_res_lo;
                            r_dbz    <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result_hi   = r_res_hi;
    assign result_lo   = r_res_lo;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_muldiv.sv
`default_nettype none
// ============================================================================
// tb_seq_muldiv
// Table-driven scoreboard bench for seq_muldiv (WIDTH = 16).
// Revision: 1.0
// ============================================================================
module tb_seq_muldiv;

    typedef struct {
        logic        op;
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] hi;
        logic [15:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic        dbz;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result_hi;
    logic [15:0] result_lo;
    logic        div_by_zero;
`ifdef SEQ_MULDIV_SIGNED_EN
    logic        signed_op;
`endif

    int   tests;
    int   fails;
    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[12];

    seq_muldiv #(
        .WIDTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
`ifdef SEQ_MULDIV_SIGNED_EN
        .signed_op   (signed_op),
`endif
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result_hi   (result_hi),
        .result_lo   (result_lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic o, input logic s, input logic [15:0] x,
                                input logic [15:0] y, input logic [15:0] hi,
                                input logic [15:0] lo, input logic dbz);
        vec_t v;
        v.op  = o;
        v.sgn = s;
        v.a   = x;
        v.b   = y;
        v.hi  = hi;
        v.lo  = lo;
        v.dbz = dbz;
        v.lat = (o && y == 16'h0) ? 1 : 16;
        return v;
    endfunction

    // Unsigned reference model.
    function automatic vec_t model(input logic o, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        if (!o)
            p = {16'h0, x} * {16'h0, y};
        else if (y == 16'h0)
            p = {x, 16'hFFFF};
        else
            p = {x % y, x / y};
        return mk(o, 1'b0, x, y, p[31:16], p[15:0], o && (y == 16'h0));
    endfunction

    task automatic push_exp(input logic [15:0] hi, input logic [15:0] lo, input logic dbz);
        exp_t e;
        e.hi  = hi;
        e.lo  = lo;
        e.dbz = dbz;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every done pulse is matched with the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            check("busy_with_done", {31'h0, busy}, 32'h0);
            if (sb_q.size() == 0) begin
                tests = tests + 1;
                fails = fails + 1;
                $display("FAIL unexpected_done: got done=1, expected no completion");
            end else begin
                mon_e = sb_q.pop_front();
                check("result_hi", {16'h0, result_hi}, {16'h0, mon_e.hi});
                check("result_lo", {16'h0, result_lo}, {16'h0, mon_e.lo});
                check("div_by_zero", {31'h0, div_by_zero}, {31'h0, mon_e.dbz});
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        start = 1'b1;
        op    = v.op;
        a     = v.a;
        b     = v.b;
`ifdef SEQ_MULDIV_SIGNED_EN
        signed_op = v.sgn;
`endif
        push_exp(v.hi, v.lo, v.dbz);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", {31'h0, busy}, 32'h1);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat = lat + 1;
        end
        check("latency", lat, v.lat);
    endtask

    initial begin
        int n;
        logic       ro;
        logic [15:0] rx;
        logic [15:0] ry;
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
`ifdef SEQ_MULDIV_SIGNED_EN
        signed_op = 1'b0;
`endif

        vecs[0]  = mk(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 16'd100,  16'd7,    16'd2,    16'd14,   1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1);
        vecs[3]  = mk(1'b0, 1'b0, 16'd3,    16'd5,    16'd0,    16'd15,   1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 16'd200,  16'd9,    16'd2,    16'd22,   1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 16'h8000, 16'd3,    16'd2,    16'h2AAA, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 16'd5,    16'd9,    16'd5,    16'd0,    1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 1'b1);
        vecs[11] = mk(1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0);

        repeat (2) @(negedge clk);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_hi_lo", {result_hi, result_lo}, 32'h0);
        check("reset_dbz", {31'h0, div_by_zero}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // Results hold while idle.
        repeat (3) @(negedge clk);
        check("hold_results", {result_hi, result_lo}, 32'h0000_FFFF);
        check("idle_busy", {31'h0, busy}, 32'h0);

        for (int i = 0; i < 8; i++) begin
            ro = 1'($urandom_range(0, 1));
            rx = 16'($urandom);
            ry = (i % 4 == 3) ? 16'h0 : 16'($urandom);
            run_vec(model(ro, rx, ry));
        end

        // Back-to-back with start held through RUN and the done cycle.
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a     = 16'd3;
        b     = 16'd5;
        push_exp(16'd0, 16'd15, 1'b0);
        @(negedge clk);
        check("b2b_busy1", {31'h0, busy}, 32'h1);
        op = 1'b1;
        a  = 16'd200;
        b  = 16'd9;
        push_exp(16'd2, 16'd22, 1'b0);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n = n + 1;
        end
        check("b2b_first_lat", n, 16);
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_gap_busy", {31'h0, busy}, 32'h1);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n = n + 1;
        end
        check("b2b_pulse_spacing", n, 16);
        @(negedge clk);
        check("b2b_done_low", {31'h0, done}, 32'h0);
        check("b2b_idle", {31'h0, busy}, 32'h0);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_done", {31'h0, done}, 32'h0);
        check("midrst_hi_lo", {result_hi, result_lo}, 32'h0);
        check("midrst_dbz", {31'h0, div_by_zero}, 32'h0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk(1'b0, 1'b0, 16'd8, 16'd8, 16'd0, 16'd64, 1'b0));

`ifdef SEQ_MULDIV_SIGNED_EN
        run_vec(mk(1'b1, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0));
        run_vec(mk(1'b0, 1'b1, 16'hFFFD, 16'h0004, 16'hFFFF, 16'hFFF4, 1'b0));
        run_vec(mk(1'b1, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0));
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_muldiv.md
# seq_muldiv

Parametrised, iterative multiply/divide unit for the ALU datapath. It computes a full double-width product, or a quotient and remainder, one bit per clock using a single shared adder/subtractor, with a start/done handshake. It fills the multiply and divide slots beside the ripple `Add` unit. It trades latency for area, replacing a combinational array.

## Interface
- `WIDTH`, default 16: operand width in bits; legal values are 4 to 64.
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request; sampled only when the unit can accept (see Operation).
- `op`, input, 1: operation select; 0 = multiply, 1 = divide.
- `a`, input, WIDTH: multiplicand or dividend.
- `b`, input, WIDTH: multiplier or divisor.
- `busy`, output, 1: high while iterating.
- `done`, output, 1: one-cycle pulse when results become valid.
- `result_hi`, output, WIDTH: product upper half, or remainder.
- `result_lo`, output, WIDTH: product lower half, or quotient.
- `div_by_zero`, output, 1: registered flag for the last completed divide with `b == 0`.

## Operation
- States:
  - IDLE: wait for a request.
  - RUN: iterate, one bit per cycle.
  - DONE: present results for one cycle.
- Transitions:
  - `start` is accepted in IDLE or DONE. On acceptance, `a`, `b` and `op` are latched, the iteration counter is cleared, and the state goes to RUN.
  - `start` is ignored in RUN.
  - RUN → DONE after exactly WIDTH iterations.
  - DONE → IDLE when `start` is low, otherwise DONE → RUN.
- Multiply: shift-add. Each iteration, if the accumulator's low bit is 1, add the multiplicand to the upper WIDTH+1 bits, then shift right one bit. The 2·WIDTH-bit product is written to `{result_hi, result_lo}`.
- Divide: restoring division. Each iteration, shift the partial remainder left, bringing in the next dividend bit. Trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit; otherwise restore.
- Divide by zero (`op=1`, `b=0` at acceptance):
  - No iterations run; the state goes to DONE on the next edge.
  - `result_lo` = all ones, `result_hi` = `a`, `div_by_zero` = 1.
- `div_by_zero` is cleared whenever any other operation completes.
- Results and `div_by_zero` hold their value until the next completion. They change only on the edge that enters DONE.
- Reset, including mid-operation, is asynchronous:
  - state goes to IDLE and the counter clears;
  - every output reads 0 (`busy`, `done`, `result_hi`, `result_lo`, `div_by_zero`);
  - no partial result is ever presented.

## Timing
- Accepting edge E0: `busy` goes to 1 after E0.
- Iteration edges E1..E_WIDTH. At E_WIDTH the results are registered, `busy` goes to 0, and `done` goes to 1.
- `done` is high for exactly one cycle, then goes low at E_WIDTH+1.
- Total latency: WIDTH cycles from the accepting edge to `done`. Divide by zero takes 1 cycle.
- Back-to-back: `start` high during the `done` cycle starts the next operation with no idle gap. Throughput is one operation per WIDTH cycles.
- `busy` and `done` are never high in the same cycle.

## Configuration
- Macro: `SEQ_MULDIV_SIGNED_EN`.
- Defined:
  - Adds input `signed_op` (1 bit), latched at acceptance.
  - When `signed_op` is 1, operands are two's complement. Magnitudes are iterated and signs fixed up on the edge entering DONE.
  - Product sign = `a` sign XOR `b` sign.
  - Quotient sign = `a` sign XOR `b` sign; remainder takes the sign of the dividend.
  - MIN / -1 wraps: quotient = MIN, remainder = 0.
  - Latency is unchanged.
- Undefined: no `signed_op` port; all operations are unsigned.

## Structure
- Package `muldiv_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the op encodings `OP_MUL` = 1'b0 and `OP_DIV` = 1'b1;
  - a counter-width function `clog2(WIDTH+1)`.
- Sub-module `muldiv_addsub`: a WIDTH+1-bit add/subtract unit with a `sub` control and carry/borrow out. It is the only arithmetic in the datapath and is shared by both operations.

## Test plan
- Multiply, WIDTH=16, a=16'hFFFF, b=16'hFFFF → `done` exactly 16 cycles after acceptance; result_hi=16'hFFFE, result_lo=16'h0001.
- Divide, a=100, b=7 → result_lo=14, result_hi=2, div_by_zero=0.
- Divide, a=16'h1234, b=0 → `done` 1 cycle after acceptance; result_lo=16'hFFFF, result_hi=16'h1234, div_by_zero=1. A following multiply 3×5 gives result_lo=15 and div_by_zero=0.
- Back-to-back: 3×5 then 200/9 with `start` held through `done` → two `done` pulses 16 cycles apart; results 15, then quotient 22 and remainder 2; `start` pulses during RUN are ignored.
- Reset asserted 5 cycles into a multiply → all outputs 0 immediately; after release, an 8×8 operation gives result_lo=64.
- With `SEQ_MULDIV_SIGNED_EN`, signed_op=1:
  - −7 / 2 → quotient −3, remainder −1;
  - −3 × 4 → {result_hi, result_lo} = 32'hFFFF_FFF4;
  - 16'h8000 / −1 → quotient 16'h8000, remainder 0.
